uart_hex_loader: RTL and testbench

- Controller sequencing the shared UART core (rx dout/rdy/rdy_clr, tx din/wr_en/tx_busy) for instruction loading.
- Consumes ASCII hex characters, assembles them MSB-first into 32-bit words and writes each word into the instruction memory at an auto-incrementing address.
- Echoes every accepted character and sends 'K' after each committed word. Sits between the UART core and the instruction memory in the top level.

---
 rtl/uart_ldr_pkg.sv | 20 ++
 rtl/hex_ascii_decode.sv | 23 ++
 rtl/uart_hex_loader.sv | 188 ++++++++++++++++++
 tb/tb_uart_hex_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ldr_pkg.sv
// Shared types and ASCII constants for the UART instruction loader and future UART command parsers.
package uart_ldr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ECHO  = 3'd1,
        ST_GAP   = 3'd2,
        ST_WRITE = 3'd3,
        ST_ACK   = 3'd4
    } state_t;

    localparam logic [7:0] CH_R   = 8'h52;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_ACK = 8'h4B;
    localparam logic [7:0] CH_ERR = 8'h3F;

    localparam int WORD_NIBBLES = 8;

endpackage

// File: rtl/hex_ascii_decode.sv
// ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f' -> nibble value, with a validity flag.
// Purely combinational; no clock, no backpressure.
module hex_ascii_decode (
    input  logic [7:0] char_i,
    output logic       is_hex_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        is_hex_o = 1'b0;
        nibble_o = 4'd0;
        if (char_i >= 8'h30 && char_i <= 8'h39) begin
            is_hex_o = 1'b1;
            nibble_o = char_i[3:0];
        end else if ((char_i >= 8'h41 && char_i <= 8'h46) ||
                     (char_i >= 8'h61 && char_i <= 8'h66)) begin
            // Both letter ranges carry 1..6 in the low nibble.
            is_hex_o = 1'b1;
            nibble_o = char_i[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/uart_hex_loader.sv
// Loads 32-bit instruction words from ASCII hex received over the UART, echoing characters and acking each word with 'K'.
// All outputs registered; bytes arriving outside IDLE stay pending on rx_rdy, transmits wait for tx_busy low.
module uart_hex_loader
    import uart_ldr_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter bit ECHO_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    output logic              rx_rdy_clr,
    output logic [7:0]        tx_din,
    output logic              tx_wr_en,
    input  logic              tx_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        nib_cnt,
    output logic              full,
    output logic              err
);

    state_t              state_q, state_d;
    logic [7:0]          char_q, char_d;
    logic                is_err_q, is_err_d;
    logic                word_done_q, word_done_d;
    logic [31:0]         word_q, word_d;
    logic [3:0]          nib_cnt_q, nib_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                full_q, full_d;
    logic                err_q, err_d;
    logic                rx_rdy_clr_q, rx_rdy_clr_d;
    logic [7:0]          tx_din_q, tx_din_d;
    logic                tx_wr_en_q, tx_wr_en_d;
    logic                mem_we_q, mem_we_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;

    logic                rx_is_hex;
    logic [3:0]          rx_nibble;
    logic                need_tx;

    hex_ascii_decode u_dec (
        .char_i   (rx_data),
        .is_hex_o (rx_is_hex),
        .nibble_o (rx_nibble)
    );

    // The error reply is sent even when echo is disabled.
    assign need_tx = is_err_q | ECHO_EN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (rx_rdy) state_d = ST_ECHO;
            ST_ECHO:  if (!need_tx || !tx_busy) state_d = ST_GAP;
            ST_GAP:   state_d = word_done_q ? ST_WRITE : ST_IDLE;
            ST_WRITE: state_d = ST_ACK;
            ST_ACK:   if (!tx_busy) state_d = ST_GAP;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        char_d       = char_q;
        is_err_d     = is_err_q;
        word_done_d  = word_done_q;
        word_d       = word_q;
        nib_cnt_d    = nib_cnt_q;
        addr_d       = addr_q;
        full_d       = full_q;
        err_d        = err_q;
        rx_rdy_clr_d = 1'b0;
        tx_din_d     = tx_din_q;
        tx_wr_en_d   = 1'b0;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_rdy) begin
                    char_d       = rx_data;
                    rx_rdy_clr_d = 1'b1;
                    is_err_d     = 1'b0;
                    word_done_d  = 1'b0;
                    if (rx_is_hex) begin
                        word_d = {word_q[27:0], rx_nibble};
                        // The eighth nibble wraps the visible count straight to 0.
                        if (nib_cnt_q == 4'(WORD_NIBBLES - 1)) begin
                            nib_cnt_d   = 4'd0;
                            word_done_d = 1'b1;
                        end else begin
                            nib_cnt_d = nib_cnt_q + 4'd1;
                        end
                    end else if (rx_data == CH_R) begin
                        addr_d    = '0;
                        nib_cnt_d = 4'd0;
                        word_d    = 32'd0;
                        full_d    = 1'b0;
                        err_d     = 1'b0;
                    end else if (rx_data == CH_CR || rx_data == CH_LF) begin
                        nib_cnt_d = 4'd0;
                        word_d    = 32'd0;
                    end else begin
                        err_d     = 1'b1;
                        is_err_d  = 1'b1;
                        nib_cnt_d = 4'd0;
                        word_d    = 32'd0;
                    end
                end
            end
            ST_ECHO: begin
                if (need_tx && !tx_busy) begin
                    tx_din_d   = is_err_q ? CH_ERR : char_q;
                    tx_wr_en_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (word_done_q) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = word_q;
                end
            end
            ST_WRITE: begin
                addr_d      = addr_q + ADDR_W'(1);
                nib_cnt_d   = 4'd0;
                word_d      = 32'd0;
                word_done_d = 1'b0;
                if (addr_q == '1) full_d = 1'b1;
            end
            ST_ACK: begin
                if (!tx_busy) begin
                    tx_din_d   = CH_ACK;
                    tx_wr_en_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_q       <= 8'd0;
            is_err_q     <= 1'b0;
            word_done_q  <= 1'b0;
            word_q       <= 32'd0;
            nib_cnt_q    <= 4'd0;
            addr_q       <= '0;
            full_q       <= 1'b0;
            err_q        <= 1'b0;
            rx_rdy_clr_q <= 1'b0;
            tx_din_q     <= 8'd0;
            tx_wr_en_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 32'd0;
        end else begin
            char_q       <= char_d;
            is_err_q     <= is_err_d;
            word_done_q  <= word_done_d;
            word_q       <= word_d;
            nib_cnt_q    <= nib_cnt_d;
            addr_q       <= addr_d;
            full_q       <= full_d;
            err_q        <= err_d;
            rx_rdy_clr_q <= rx_rdy_clr_d;
            tx_din_q     <= tx_din_d;
            tx_wr_en_q   <= tx_wr_en_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign rx_rdy_clr = rx_rdy_clr_q;
    assign tx_din     = tx_din_q;
    assign tx_wr_en   = tx_wr_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign nib_cnt    = nib_cnt_q;
    assign full       = full_q;
    assign err        = err_q;

endmodule

// File: tb/tb_uart_hex_loader.sv
// Directed bench for uart_hex_loader with a small UART busy model and transmit/write monitors.
module tb_uart_hex_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_rdy = 1'b0;
    logic          rx_rdy_clr;
    logic [7:0]    tx_din;
    logic          tx_wr_en;
    logic          tx_busy;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    nib_cnt;
    logic          full;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;
    int n_sent = 0;
    int n_clr = 0;
    int n_viol = 0;

    logic        busy_force = 1'b0;
    logic [2:0]  busy_cnt = 3'd0;

    logic [7:0]    txq[$];
    logic [31:0]   wdq[$];
    logic [AW-1:0] waq[$];

    uart_hex_loader #(.ADDR_W(AW), .ECHO_EN(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .rx_rdy_clr (rx_rdy_clr),
        .tx_din     (tx_din),
        .tx_wr_en   (tx_wr_en),
        .tx_busy    (tx_busy),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .nib_cnt    (nib_cnt),
        .full       (full),
        .err        (err)
    );

    always #5 clk = ~clk;

    // UART transmitter: busy rises one cycle after the strobe and lasts four cycles.
    assign tx_busy = busy_force | (busy_cnt != 3'd0);
    always @(posedge clk) begin
        if (tx_wr_en)            busy_cnt <= 3'd4;
        else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 3'd1;
    end

    always @(negedge clk) begin
        if (tx_wr_en) begin
            txq.push_back(tx_din);
            if (tx_busy) n_viol++;
        end
        if (mem_we) begin
            waq.push_back(mem_addr);
            wdq.push_back(mem_wdata);
        end
        if (rx_rdy_clr) n_clr++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rx_rdy_clr"}, 32'(rx_rdy_clr), 32'd0);
        chk({tag, "_tx_din"},     32'(tx_din),     32'd0);
        chk({tag, "_tx_wr_en"},   32'(tx_wr_en),   32'd0);
        chk({tag, "_mem_we"},     32'(mem_we),     32'd0);
        chk({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
        chk({tag, "_mem_wdata"},  mem_wdata,       32'd0);
        chk({tag, "_nib_cnt"},    32'(nib_cnt),    32'd0);
        chk({tag, "_full"},       32'(full),       32'd0);
        chk({tag, "_err"},        32'(err),        32'd0);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] c);
        bit done;
        done = 1'b0;
        @(negedge clk);
        rx_data = c;
        rx_rdy  = 1'b1;
        n_sent++;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (rx_rdy_clr) begin
                rx_rdy = 1'b0;
                done   = 1'b1;
            end
        end
        if (!done) begin
            chk("rx_clr_timeout", 32'd0, 32'd1);
            rx_rdy = 1'b0;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic chk_tx(input string tag, input int base, input string exp);
        chk({tag, "_tx_count"}, 32'(txq.size() - base), 32'(exp.len()));
        for (int i = 0; i < exp.len(); i++)
            if (base + i < txq.size()) chk({tag, "_tx_byte"}, 32'(txq[base + i]), 32'(exp[i]));
    endtask

    task automatic chk_wr(input string tag, input int base, input int idx,
                          input logic [AW-1:0] addr, input logic [31:0] data);
        if (base + idx < wdq.size()) begin
            chk({tag, "_waddr"}, 32'(waq[base + idx]), 32'(addr));
            chk({tag, "_wdata"}, wdq[base + idx], data);
        end else begin
            chk({tag, "_wmissing"}, 32'(wdq.size() - base), 32'(idx + 1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "bench timeout");
    end

    initial begin
        int tb, wb;
        bit found;

        // Reset state
        settle(3);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        settle(2);

        // DEADBEEF: eight echoes, one write at 0, then 'K'
        tb = txq.size(); wb = wdq.size();
        send_str("DEA");
        settle(15);
        chk("partial_nib_cnt", 32'(nib_cnt), 32'd3);
        send_str("DBEEF");
        settle(40);
        chk_tx("deadbeef", tb, "DEADBEEFK");
        chk("deadbeef_nwr", 32'(wdq.size() - wb), 32'd1);
        chk_wr("deadbeef", wb, 0, 2'd0, 32'hDEADBEEF);
        chk("deadbeef_addr", 32'(mem_addr), 32'd1);
        chk("deadbeef_nib", 32'(nib_cnt), 32'd0);

        // Partial word discarded by CR
        tb = txq.size(); wb = wdq.size();
        send_str("R12\x0d0000000A");
        settle(40);
        chk_tx("cr", tb, "R12\x0d0000000AK");
        chk("cr_nwr", 32'(wdq.size() - wb), 32'd1);
        chk_wr("cr", wb, 0, 2'd0, 32'h0000000A);
        chk("cr_err", 32'(err), 32'd0);

        // Transmitter busy for 200 cycles
        tb = txq.size();
        busy_force = 1'b1;
        settle(2);
        rx_data = "5";
        rx_rdy  = 1'b1;
        n_sent++;
        @(negedge clk);
        chk("busy_clr_pulse", 32'(rx_rdy_clr), 32'd1);
        rx_rdy = 1'b0;
        @(negedge clk);
        chk("busy_clr_once", 32'(rx_rdy_clr), 32'd0);
        settle(200);
        chk("busy_no_tx", 32'(txq.size() - tb), 32'd0);
        busy_force = 1'b0;
        settle(20);
        chk_tx("busy", tb, "5");
        chk("busy_nib", 32'(nib_cnt), 32'd1);

        // Illegal character, then reset command
        tb = txq.size();
        send("G");
        settle(20);
        chk_tx("illegal", tb, "?");
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_nib", 32'(nib_cnt), 32'd0);
        send("R");
        settle(20);
        chk("r_err", 32'(err), 32'd0);
        chk("r_addr", 32'(mem_addr), 32'd0);

        // Address wrap with a 4-deep memory
        wb = wdq.size();
        send_str("000000010000000200000003");
        settle(40);
        chk("wrap_full_before", 32'(full), 32'd0);
        send_str("00000004");
        settle(40);
        chk("wrap_full", 32'(full), 32'd1);
        chk("wrap_addr", 32'(mem_addr), 32'd0);
        send_str("00000005");
        settle(40);
        chk("wrap_nwr", 32'(wdq.size() - wb), 32'd5);
        for (int i = 0; i < 5; i++)
            chk_wr("wrap", wb, i, AW'(i), 32'(i + 1));
        chk("wrap_full_kept", 32'(full), 32'd1);
        chk("wrap_addr_after", 32'(mem_addr), 32'd1);

        // Reset while the write strobe is high
        send_str("12345678");
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (mem_we) found = 1'b1;
        end
        chk("rst_saw_write", 32'(found), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk_zero_outputs("midrst");
        tb = txq.size(); wb = wdq.size();
        settle(3);
        rst_n = 1'b1;
        settle(30);
        chk("midrst_no_tx", 32'(txq.size() - tb), 32'd0);
        chk("midrst_no_we", 32'(wdq.size() - wb), 32'd0);
        send("7");
        settle(20);
        chk_tx("post_rst", tb, "7");
        chk("post_rst_nib", 32'(nib_cnt), 32'd1);

        chk("clr_per_byte", 32'(n_clr), 32'(n_sent));
        chk("tx_while_busy", 32'(n_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
